ps2_rx_frame_ctrl: RTL

Frame controller that sits directly downstream of the PS2 debouncer. It takes the debounced PS2 clock and data lines and sequences the 11-bit device-to-host frame: start bit, 8 data bits LSB first, odd parity, stop bit. It checks each frame, reports good bytes and errors, and folds E0 (extended) and F0 (break) prefixes into one key event for the keyboard/game-input logic. A watchdog aborts stalled frames.

---
 rtl/ps2_rx_frame_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_frame_ctrl.sv
// PS2 device-to-host frame receiver with E0/F0 prefix folding and a stall watchdog.
// Latency: rx_valid, parity_err and frame_err are registered one cycle after the stop-bit fall; key_valid pulses together with rx_valid.
// Backpressure: none; the PS2 line is paced by the device and every result is a single-cycle pulse.
// Ports: clk/rst (async active-high); ps2_clk_db/ps2_data_db debounced PS2 lines;
//        rx_data/rx_valid good bytes; parity_err/frame_err dropped frames;
//        key_code/key_ext/key_release/key_valid folded key events; busy while a frame is in flight.
module ps2_rx_frame_ctrl #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int TMR_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_db,
   input  logic       ps2_data_db,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       key_valid,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_prev_clk;
   logic [3:0]       r_bit_cnt;
   logic [7:0]       r_shreg;
   logic             r_par;
   logic [TMR_W-1:0] r_timer;
   logic             r_ext_pend;
   logic             r_rel_pend;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_parity_err;
   logic             r_frame_err;
   logic [7:0]       r_key_code;
   logic             r_key_ext;
   logic             r_key_release;
   logic             r_key_valid;

   logic w_fall;
   logic w_timeout;
   logic w_start;
   logic w_shift;
   logic w_par_ld;
   logic w_good;
   logic w_perr;
   logic w_ferr;

   assign w_fall = r_prev_clk & ~ps2_clk_db;
   // A fall in the terminal-count cycle wins over the timeout.
   assign w_timeout = (r_state != IDLE) && !w_fall &&
                      (r_timer == TMR_W'(TIMEOUT_CYC - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_par_ld    = 1'b0;
      w_good      = 1'b0;
      w_perr      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         IDLE: begin
            // A fall with data high is a spurious edge: ignored silently.
            if (w_fall && !ps2_data_db) begin
               w_state_nxt = DATA;
               w_start     = 1'b1;
            end
         end
         DATA: begin
            if (w_fall) begin
               w_shift = 1'b1;
               if (r_bit_cnt == 4'd7) w_state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (w_fall) begin
               w_par_ld    = 1'b1;
               w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (w_fall) begin
               w_state_nxt = IDLE;
               // Stop-bit errors take precedence over parity errors.
               if (!ps2_data_db)              w_ferr = 1'b1;
               else if (!(^r_shreg ^ r_par))  w_perr = 1'b1;
               else                           w_good = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_timeout) begin
         w_state_nxt = IDLE;
         w_ferr      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev_clk    <= 1'b1;
         r_bit_cnt     <= '0;
         r_shreg       <= '0;
         r_par         <= 1'b0;
         r_timer       <= '0;
         r_ext_pend    <= 1'b0;
         r_rel_pend    <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_parity_err  <= 1'b0;
         r_frame_err   <= 1'b0;
         r_key_code    <= '0;
         r_key_ext     <= 1'b0;
         r_key_release <= 1'b0;
         r_key_valid   <= 1'b0;
      end else begin
         r_prev_clk   <= ps2_clk_db;
         r_rx_valid   <= w_good;
         r_parity_err <= w_perr;
         r_frame_err  <= w_ferr;
         r_key_valid  <= 1'b0;

         if (r_state == IDLE || w_fall) r_timer <= '0;
         else                           r_timer <= r_timer + TMR_W'(1);

         if (w_start) r_bit_cnt <= '0;
         if (w_shift) begin
            r_shreg   <= {ps2_data_db, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
         if (w_par_ld) r_par <= ps2_data_db;

         if (w_good) begin
            r_rx_data <= r_shreg;
            if (r_shreg == 8'hE0) begin
               r_ext_pend <= 1'b1;
            end else if (r_shreg == 8'hF0) begin
               r_rel_pend <= 1'b1;
            end else begin
               r_key_code    <= r_shreg;
               r_key_ext     <= r_ext_pend;
               r_key_release <= r_rel_pend;
               r_key_valid   <= 1'b1;
               r_ext_pend    <= 1'b0;
               r_rel_pend    <= 1'b0;
            end
         end else if (w_perr || w_ferr) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
         end
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign parity_err  = r_parity_err;
   assign frame_err   = r_frame_err;
   assign key_code    = r_key_code;
   assign key_ext     = r_key_ext;
   assign key_release = r_key_release;
   assign key_valid   = r_key_valid;
   assign busy        = (r_state != IDLE);

endmodule
